cr_kme_key_tlv_arb: RTL and testbench

//  Frame-atomic round-robin arbiter that shares the key TLV reassembler user write port
//  (usr_ob_wr/usr_ob_tlv/usr_ob_full/usr_ob_afull) between N_REQ key-producing engines.

---
 rtl/cr_kme_key_tlv_arb_pkg.sv | 22 ++
 rtl/cr_kme_rr_pick.sv | 32 +++
 rtl/cr_kme_key_tlv_arb.sv | 92 +++++++++
 tb/tb_cr_kme_key_tlv_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_kme_key_tlv_arb_pkg.sv
// Shared types and constants for the KME key TLV arbiter slice.
// Holds the TLV word layout, the default requester count and the arbiter state type.
package cr_kme_key_tlv_arb_pkg;

    localparam int KME_KEY_ARB_N_REQ = 4;

    typedef struct packed {
        logic        insert;
        logic [7:0]  ordern;
        logic [7:0]  typen;
        logic        sot;
        logic        eot;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } tlvp_if_bus_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } kme_key_arb_state_e;

endpackage

// File: rtl/cr_kme_rr_pick.sv
// Combinational rotate-priority picker.
// Returns the first set request at or above ptr, wrapping from N-1 back to 0.
module cr_kme_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/cr_kme_key_tlv_arb.sv
// Frame-atomic round-robin arbiter sharing the key TLV reassembler write port.
// A winner keeps the port from its SOT word through its EOT word; one bubble per grant.
module cr_kme_key_tlv_arb
    import cr_kme_key_tlv_arb_pkg::*;
#(
    parameter int N_REQ = KME_KEY_ARB_N_REQ,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   cfg_req_en,
    input  logic [N_REQ-1:0]   req_valid,
    input  tlvp_if_bus_t       req_tlv [N_REQ],
    output logic [N_REQ-1:0]   req_rdy,
    output logic               usr_ob_wr,
    output tlvp_if_bus_t       usr_ob_tlv,
    input  logic               usr_ob_full,
    input  logic               usr_ob_afull,
    output logic               arb_busy,
    output logic [PTR_W-1:0]   arb_owner,
    output logic               arb_proto_err,
    output logic               stat_arb_stall
);

    kme_key_arb_state_e state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic               word_seen;
    logic [N_REQ-1:0]   cand;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               owner_go;
    logic               sot_err;
    tlvp_if_bus_t       own_word;
    logic [PTR_W-1:0]   owner_inc;

    assign cand      = cfg_req_en & req_valid;
    assign own_word  = req_tlv[arb_owner];
    assign owner_go  = (state == LOCK) & req_valid[arb_owner] & ~usr_ob_afull & ~usr_ob_full;
    assign sot_err   = owner_go & (word_seen ? own_word.sot : ~own_word.sot);
    assign owner_inc = (arb_owner == PTR_W'(N_REQ - 1)) ? '0 : arb_owner + 1'b1;
    assign arb_busy  = (state == LOCK);

    cr_kme_rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Only the owner is ever ready; the enable mask is ignored once a frame is locked.
    always_comb begin
        state_nxt          = state;
        req_rdy            = '0;
        req_rdy[arb_owner] = owner_go;
        case (state)
            IDLE: if (pick_valid) state_nxt = LOCK;
            LOCK: if (owner_go && own_word.eot) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            arb_owner      <= '0;
            word_seen      <= 1'b0;
            usr_ob_wr      <= 1'b0;
            usr_ob_tlv     <= '0;
            arb_proto_err  <= 1'b0;
            stat_arb_stall <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                arb_owner <= pick_idx;
                word_seen <= 1'b0;
            end
            if (owner_go) begin
                word_seen  <= 1'b1;
                usr_ob_tlv <= own_word;
                if (own_word.eot) rr_ptr <= owner_inc;
            end
            usr_ob_wr      <= owner_go;
            // A write landing on a full reassembler means the afull slack was violated.
            arb_proto_err  <= sot_err | (usr_ob_wr & usr_ob_full);
            stat_arb_stall <= (|cand) & ~owner_go;
        end
    end

endmodule

// File: tb/tb_cr_kme_key_tlv_arb.sv
// Self-checking bench for cr_kme_key_tlv_arb.
// Per-requester frame queues feed a frame-level round-robin reference model.
module tb_cr_kme_key_tlv_arb;
    import cr_kme_key_tlv_arb_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] cfg_req_en;
    logic [N-1:0] req_valid;
    tlvp_if_bus_t req_tlv [N];
    logic [N-1:0] req_rdy;
    logic         usr_ob_wr;
    tlvp_if_bus_t usr_ob_tlv;
    logic         usr_ob_full;
    logic         usr_ob_afull;
    logic         arb_busy;
    logic [1:0]   arb_owner;
    logic         arb_proto_err;
    logic         stat_arb_stall;

    cr_kme_key_tlv_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_req_en     (cfg_req_en),
        .req_valid      (req_valid),
        .req_tlv        (req_tlv),
        .req_rdy        (req_rdy),
        .usr_ob_wr      (usr_ob_wr),
        .usr_ob_tlv     (usr_ob_tlv),
        .usr_ob_full    (usr_ob_full),
        .usr_ob_afull   (usr_ob_afull),
        .arb_busy       (arb_busy),
        .arb_owner      (arb_owner),
        .arb_proto_err  (arb_proto_err),
        .stat_arb_stall (stat_arb_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending words per requester plus frame ownership bookkeeping.
    tlvp_if_bus_t q [N][$];
    bit           m_in_frame;
    int           m_owner;
    int           m_ptr;
    int           m_widx;
    bit           m_wr;

    bit           e_wr, e_err, e_stall, e_busy;
    tlvp_if_bus_t e_tlv;
    int           e_owner;
    logic [N-1:0] e_rdy, o_rdy;

    task automatic push_frame(input int r, input int len);
        tlvp_if_bus_t w;
        for (int j = 0; j < len; j++) begin
            w       = '0;
            w.tdata = {$urandom, $urandom};
            w.tuser = 8'($urandom);
            w.typen = 8'($urandom);
            w.sot   = (j == 0);
            w.eot   = (j == len - 1);
            q[r].push_back(w);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) q[i].delete();
        m_in_frame = 0;
        m_ptr      = 0;
        m_owner    = 0;
        m_widx     = 0;
        m_wr       = 0;
        e_tlv      = '0;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        usr_ob_afull = 1'b0;
        usr_ob_full  = 1'b0;
        for (int i = 0; i < N; i++) req_tlv[i] = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive queue heads, predict the cycle from the frame rules, advance.
    task automatic step();
        logic [N-1:0] cand;
        tlvp_if_bus_t w;
        bit           acc, bad;
        int           win;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (q[i].size() > 0);
            req_tlv[i]   = (q[i].size() > 0) ? q[i][0] : '0;
        end
        #4;
        cand  = cfg_req_en & req_valid;
        e_rdy = '0;
        acc   = 0;
        bad   = 0;
        win   = -1;
        w     = '0;
        if (!m_in_frame) begin
            for (int k = 0; k < N; k++)
                if (win < 0 && cand[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end else if (q[m_owner].size() > 0 && !usr_ob_afull && !usr_ob_full) begin
            e_rdy[m_owner] = 1'b1;
            acc = 1;
            w   = q[m_owner].pop_front();
            bad = (m_widx == 0) ? !w.sot : w.sot;
        end
        o_rdy   = req_rdy;
        e_err   = bad | (m_wr & usr_ob_full);
        e_stall = (cand != 0) && !acc;
        e_wr    = acc;
        if (acc) begin
            e_tlv = w;
            m_widx++;
            if (w.eot) begin
                m_in_frame = 0;
                m_ptr      = (m_owner + 1) % N;
            end
        end
        if (win >= 0) begin
            m_in_frame = 1;
            m_owner    = win;
            m_widx     = 0;
        end
        e_busy  = m_in_frame;
        e_owner = m_owner;
        m_wr    = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        cfg_req_en = '0; req_valid = '0; usr_ob_full = 0; usr_ob_afull = 0;
        for (int i = 0; i < N; i++) req_tlv[i] = '0;
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({usr_ob_wr, usr_ob_tlv, req_rdy, arb_busy, arb_owner, arb_proto_err, stat_arb_stall} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs got wr=%b tlv=%h rdy=%b busy=%b owner=%0d err=%b stall=%b want all zero",
                     usr_ob_wr, usr_ob_tlv, req_rdy, arb_busy, arb_owner, arb_proto_err, stat_arb_stall);
        end
        apply_reset();
    endtask

    task automatic test_single_frame();
        int n_wr = 0;
        apply_reset();
        cfg_req_en = 4'b1111;
        push_frame(0, 3);
        for (int s = 0; s < 6; s++) begin
            step();
            if (usr_ob_wr) n_wr++;
            n_vec++;
            if (usr_ob_wr !== e_wr) begin n_err++; $display("[TB] FAIL single_wr step %0d got %b want %b", s, usr_ob_wr, e_wr); end
            n_vec++;
            if (arb_busy !== e_busy) begin n_err++; $display("[TB] FAIL single_busy step %0d got %b want %b", s, arb_busy, e_busy); end
            if (e_wr) begin
                n_vec++;
                if (usr_ob_tlv !== e_tlv) begin n_err++; $display("[TB] FAIL single_tlv step %0d got %h want %h", s, usr_ob_tlv, e_tlv); end
            end
        end
        n_vec++;
        if (n_wr != 3) begin n_err++; $display("[TB] FAIL single_wr_count got %0d want 3", n_wr); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        bit prev_busy = 0;
        apply_reset();
        cfg_req_en = 4'b1111;
        push_frame(0, 2); push_frame(0, 2);
        for (int r = 1; r < N; r++) push_frame(r, 2);
        for (int s = 0; s < 18; s++) begin
            step();
            if (arb_busy && !prev_busy) order.push_back(int'(arb_owner));
            prev_busy = arb_busy;
            n_vec++;
            if (arb_busy !== e_busy || arb_owner !== 2'(e_owner)) begin
                n_err++;
                $display("[TB] FAIL rr_state step %0d got busy=%b owner=%0d want busy=%b owner=%0d", s, arb_busy, arb_owner, e_busy, e_owner);
            end
            if (e_wr) begin
                n_vec++;
                if (usr_ob_tlv !== e_tlv) begin n_err++; $display("[TB] FAIL rr_tlv step %0d got %h want %h", s, usr_ob_tlv, e_tlv); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (i >= order.size() || order[i] != exp_order[i]) begin
                n_err++;
                $display("[TB] FAIL rr_order frame %0d got %0d want %0d", i, (i < order.size()) ? order[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_afull_throttle();
        apply_reset();
        cfg_req_en = 4'b1111;
        push_frame(1, 8);
        for (int s = 0; s < 14; s++) begin
            usr_ob_afull = (s >= 3 && s <= 6);
            step();
            n_vec++;
            if (o_rdy !== e_rdy) begin n_err++; $display("[TB] FAIL afull_rdy step %0d got %b want %b", s, o_rdy, e_rdy); end
            n_vec++;
            if (stat_arb_stall !== e_stall) begin n_err++; $display("[TB] FAIL afull_stall step %0d got %b want %b", s, stat_arb_stall, e_stall); end
            n_vec++;
            if (usr_ob_wr !== e_wr || (e_wr && usr_ob_tlv !== e_tlv)) begin
                n_err++;
                $display("[TB] FAIL afull_word step %0d got wr=%b %h want wr=%b %h", s, usr_ob_wr, usr_ob_tlv, e_wr, e_tlv);
            end
        end
        usr_ob_afull = 1'b0;
    endtask

    task automatic test_enable_mask();
        apply_reset();
        cfg_req_en = 4'b1010;
        for (int r = 0; r < N; r++)
            for (int f = 0; f < 3; f++) push_frame(r, $urandom_range(1, 3));
        for (int s = 0; s < 40; s++) begin
            step();
            n_vec++;
            if (arb_owner !== 2'(e_owner) || arb_busy !== e_busy) begin
                n_err++;
                $display("[TB] FAIL mask_owner step %0d got %0d/%b want %0d/%b", s, arb_owner, arb_busy, e_owner, e_busy);
            end
            n_vec++;
            if (arb_busy && (arb_owner == 2'd0 || arb_owner == 2'd2)) begin
                n_err++;
                $display("[TB] FAIL mask_disabled_win step %0d got owner %0d want 1 or 3", s, arb_owner);
            end
        end
    endtask

    task automatic test_proto_err();
        tlvp_if_bus_t w;
        int n_pulse = 0;
        apply_reset();
        cfg_req_en = 4'b1111;
        for (int j = 0; j < 3; j++) begin
            w = '0;
            w.tdata = {$urandom, $urandom};
            w.sot = (j == 1);
            w.eot = (j == 2);
            q[0].push_back(w);
        end
        push_frame(1, 3);
        for (int s = 0; s < 12; s++) begin
            usr_ob_full = (s == 6);
            step();
            if (arb_proto_err) n_pulse++;
            n_vec++;
            if (arb_proto_err !== e_err) begin n_err++; $display("[TB] FAIL proto_err step %0d got %b want %b", s, arb_proto_err, e_err); end
            n_vec++;
            if (usr_ob_wr !== e_wr || (e_wr && usr_ob_tlv !== e_tlv)) begin
                n_err++;
                $display("[TB] FAIL proto_word step %0d got wr=%b %h want wr=%b %h", s, usr_ob_wr, usr_ob_tlv, e_wr, e_tlv);
            end
        end
        usr_ob_full = 1'b0;
        n_vec++;
        if (n_pulse != 3) begin n_err++; $display("[TB] FAIL proto_pulse_count got %0d want 3", n_pulse); end
    endtask

    task automatic test_reset_mid_frame();
        int n_wr = 0;
        apply_reset();
        cfg_req_en = 4'b1111;
        push_frame(0, 5);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({usr_ob_wr, usr_ob_tlv, req_rdy, arb_busy, arb_owner, arb_proto_err, stat_arb_stall} !== '0) begin
            n_err++;
            $display("[TB] FAIL midreset_outputs got wr=%b rdy=%b busy=%b owner=%0d err=%b stall=%b want all zero",
                     usr_ob_wr, req_rdy, arb_busy, arb_owner, arb_proto_err, stat_arb_stall);
        end
        model_clear();
        push_frame(2, 2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            if (usr_ob_wr) n_wr++;
            n_vec++;
            if (usr_ob_wr !== e_wr || (e_wr && usr_ob_tlv !== e_tlv) || arb_owner !== 2'(e_owner)) begin
                n_err++;
                $display("[TB] FAIL midreset_word step %0d got wr=%b owner=%0d %h want wr=%b owner=%0d %h",
                         s, usr_ob_wr, arb_owner, usr_ob_tlv, e_wr, e_owner, e_tlv);
            end
        end
        n_vec++;
        if (n_wr != 2) begin n_err++; $display("[TB] FAIL midreset_wr_count got %0d want 2", n_wr); end
    endtask

    task automatic test_random();
        int  steps = 0;
        bit  pending;
        apply_reset();
        cfg_req_en = 4'($urandom_range(1, 15));
        for (int r = 0; r < N; r++)
            repeat ($urandom_range(0, 3)) push_frame(r, $urandom_range(1, 4));
        do begin
            usr_ob_afull = ($urandom_range(0, 3) == 0);
            step();
            steps++;
            n_vec++;
            if (o_rdy !== e_rdy || usr_ob_wr !== e_wr || (e_wr && usr_ob_tlv !== e_tlv)) begin
                n_err++;
                $display("[TB] FAIL rand_data step %0d got rdy=%b wr=%b %h want rdy=%b wr=%b %h",
                         steps, o_rdy, usr_ob_wr, usr_ob_tlv, e_rdy, e_wr, e_tlv);
            end
            n_vec++;
            if (stat_arb_stall !== e_stall || arb_busy !== e_busy || arb_owner !== 2'(e_owner) || arb_proto_err !== e_err) begin
                n_err++;
                $display("[TB] FAIL rand_ctrl step %0d got stall=%b busy=%b owner=%0d err=%b want %b %b %0d %b",
                         steps, stat_arb_stall, arb_busy, arb_owner, arb_proto_err, e_stall, e_busy, e_owner, e_err);
            end
            pending = m_in_frame;
            for (int r = 0; r < N; r++) if (cfg_req_en[r] && q[r].size() > 0) pending = 1;
        end while (pending && steps < 300);
        usr_ob_afull = 1'b0;
        n_vec++;
        if (pending) begin n_err++; $display("[TB] FAIL rand_drain got pending after %0d cycles want drained", steps); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_afull_throttle();
        test_enable_mask();
        test_proto_err();
        test_reset_mid_frame();
        repeat (4) test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
